// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: fixed-latency multiply, radix-2 restoring divide.
// Define MULDIV_EARLY_OUT_EN to let trivial divides finish one cycle after start.
`timescale 1ns/1ps

module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

  logic [1:0]      state_q,  state_d;
  logic [XLEN-1:0] a_q,      a_d;
  logic [XLEN-1:0] b_q,      b_d;
  logic [2:0]      f3_q,     f3_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [XLEN-1:0] quo_q,    quo_d;
  logic [XLEN-1:0] rem_q,    rem_d;
  logic [XLEN-1:0] result_q, result_d;

  // Multiply: sign-extend both operands to 2*XLEN so one unsigned product
  // serves signed, mixed and unsigned forms.
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_wide, mul_b_wide, mul_prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_a_sgn  = (f3_q[1:0] != 2'b11) & a_q[XLEN-1];
    mul_b_sgn  = (f3_q[1:0] == 2'b01) & b_q[XLEN-1];
    mul_a_wide = {{XLEN{mul_a_sgn}}, a_q};
    mul_b_wide = {{XLEN{mul_b_sgn}}, b_q};
    mul_prod   = mul_a_wide * mul_b_wide;
    mul_res    = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // Divide: one restoring step per cycle on magnitudes, dividend shifted out of quo_q.
  logic            div_signed, div_a_neg, div_b_neg;
  logic [XLEN-1:0] div_b_mag;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            step_ge;
  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] quo_fin, rem_fin, div_res;

  always_comb begin
    div_signed = ~f3_q[0];
    div_a_neg  = div_signed & a_q[XLEN-1];
    div_b_neg  = div_signed & b_q[XLEN-1];
    div_b_mag  = div_b_neg ? (-b_q) : b_q;
    rem_shift  = {rem_q, quo_q[XLEN-1]};
    rem_diff   = rem_shift - {1'b0, div_b_mag};
    step_ge    = ~rem_diff[XLEN];
    rem_step   = step_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_step   = {quo_q[XLEN-2:0], step_ge};
    // A zero divisor yields all-ones magnitude; force it so the sign fix can't disturb it.
    if (b_q == '0) begin
      quo_fin = '1;
    end else begin
      quo_fin = (div_a_neg ^ div_b_neg) ? (-quo_step) : quo_step;
    end
    rem_fin = div_a_neg ? (-rem_step) : rem_step;
    div_res = f3_q[1] ? rem_fin : quo_fin;
  end

  // Operand conditioning on the incoming request, used when it is accepted.
  logic            in_a_neg;
  logic [XLEN-1:0] in_a_mag;

  always_comb begin
    in_a_neg = ~funct3[0] & a[XLEN-1];
    in_a_mag = in_a_neg ? (-a) : a;
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            in_b_neg;
  logic [XLEN-1:0] in_b_mag;
  logic            early_zero, early_ovf, early_small, early_hit;
  logic [XLEN-1:0] early_res;

  always_comb begin
    in_b_neg    = ~funct3[0] & b[XLEN-1];
    in_b_mag    = in_b_neg ? (-b) : b;
    early_zero  = (b == '0);
    early_ovf   = ~funct3[0] & (a == SMIN) & (b == '1);
    early_small = (in_a_mag < in_b_mag);
    early_hit   = early_zero | early_ovf | early_small;
    early_res   = '0;
    if (early_zero) begin
      early_res = funct3[1] ? a : '1;
    end else if (early_ovf) begin
      early_res = funct3[1] ? '0 : a;
    end else if (early_small) begin
      early_res = funct3[1] ? a : '0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    f3_d     = f3_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d   = a;
            b_d   = b;
            f3_d  = funct3;
            cnt_d = '0;
            quo_d = in_a_mag;
            rem_d = '0;
            if (!funct3[2]) begin
              state_d = MUL;
            end else begin
              state_d = DIV;
`ifdef MULDIV_EARLY_OUT_EN
              if (early_hit) begin
                state_d  = DONE;
                result_d = early_res;
              end
`endif
            end
          end
        end
        MUL: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == MUL_LAST) begin
            state_d  = DONE;
            result_d = mul_res;
          end
        end
        DIV: begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DIV_LAST) begin
            state_d  = DONE;
            result_d = div_res;
          end
        end
        // DONE never samples start, so a held instruction is not taken twice.
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  // stall is qualified with reset so a held start cannot freeze the pipe during reset.
  assign stall  = reset & start & (state_q != DONE) & ~flush;
  assign busy   = (state_q == MUL) | (state_q == DIV);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, flush/reset aborts.
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int MS   = 2;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    int          id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_res = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: cyc=%0d got done=1 result=%h want done=0", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("op%0d_result", mon_e.id), result, mon_e.res);
        chk($sformatf("op%0d_done_cycle", mon_e.id), cyc, mon_e.at);
        $display("op%0d done at cycle %0d result=%h", mon_e.id, cyc, result);
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && done === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%b done=%b want both 0", busy, done);
    end
  endtask

  function automatic int div_lat(input bit eo);
    return (EARLY && eo) ? 1 : XLEN + 1;
  endfunction

  // Issue one op, hold start through the DONE cycle (like EX), scramble inputs meanwhile.
  task automatic op(input int id, input logic [2:0] f, input logic [31:0] aa,
                    input logic [31:0] bb, input logic [31:0] res, input bit eo);
    int t0;
    int lat;
    lat = f[2] ? div_lat(eo) : MS + 1;
    wait_idle();
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; start = 1'b1;
    funct3 = f; a = aa; b = bb;
    t0 = cyc;
    sb.push_back('{res, t0 + lat, id});
    last_res = res;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("op%0d_stall_c%0d", id, k), 32'(stall), 32'(k < lat));
      @(posedge clk); #1;
      if (k < lat) begin
        a = $urandom; b = $urandom; funct3 = 3'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk($sformatf("op%0d_after_busy", id), 32'(busy), 32'd0);
    chk($sformatf("op%0d_after_done", id), 32'(done), 32'd0);
  endtask

  // Start a divide and kill it in cycle 10 with flush or with reset.
  task automatic abort(input int id, input bit use_rst);
    logic [31:0] want;
    wait_idle();
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; start = 1'b1;
    funct3 = 3'b100; a = 32'd100; b = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("ab%0d_stall_c%0d", id, k), 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    if (use_rst) reset = 1'b0;
    else         flush = 1'b1;
    want = use_rst ? 32'h0 : last_res;
    @(negedge clk);
    chk($sformatf("ab%0d_c10_stall", id), 32'(stall), 32'd0);
    chk($sformatf("ab%0d_c10_busy", id), 32'(busy), use_rst ? 32'd0 : 32'd1);
    chk($sformatf("ab%0d_c10_done", id), 32'(done), 32'd0);
    chk($sformatf("ab%0d_c10_result", id), result, want);
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk($sformatf("ab%0d_c11_busy", id), 32'(busy), 32'd0);
    chk($sformatf("ab%0d_c11_done", id), 32'(done), 32'd0);
    repeat (40) @(negedge clk);
    chk($sformatf("ab%0d_late_result", id), result, want);
    last_res = want;
    $display("abort%0d (%s) at cycle 10 result=%h", id, use_rst ? "reset" : "flush", result);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b1; flush = 1'b0;
    funct3 = 3'b000; a = 32'd7; b = 32'd5;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),  32'd0);
    chk("rst_done",   32'(done),  32'd0);
    chk("rst_stall",  32'(stall), 32'd0);
    chk("rst_result", result,     32'h0);

    // Multiplies
    op( 1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    op( 2, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    op( 3, 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
    op( 4, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    op( 5, 3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0);
    op( 6, 3'b011, 32'h80000000, 32'd4,        32'h00000002, 1'b0);
    op( 7, 3'b010, 32'd2,        32'hFFFFFFFF, 32'h00000001, 1'b0);
    op( 8, 3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0);
    // Divides
    op( 9, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    op(10, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    op(11, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    op(12, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    op(13, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    op(14, 3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1);
    op(15, 3'b111, 32'd5,        32'd0,        32'h00000005, 1'b1);
    op(16, 3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1);
    op(17, 3'b101, 32'd100,      32'd7,        32'h0000000E, 1'b0);
    op(18, 3'b111, 32'd100,      32'd7,        32'h00000002, 1'b0);
    op(19, 3'b100, 32'd3,        32'hFFFFFFF6, 32'h00000000, 1'b1);
    op(20, 3'b110, 32'hFFFFFFFD, 32'd10,       32'hFFFFFFFD, 1'b1);
    op(21, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    op(22, 3'b100, 32'd20,       32'hFFFFFFFC, 32'hFFFFFFFB, 1'b0);
    op(23, 3'b101, 32'h80000000, 32'd3,        32'h2AAAAAAA, 1'b0);
    op(24, 3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0);
    op(25, 3'b101, 32'd3,        32'hFFFFFFF6, 32'h00000000, 1'b1);
    op(26, 3'b100, 32'hFFFFFFF6, 32'd3,        32'hFFFFFFFD, 1'b0);
    op(27, 3'b101, 32'hFFFFFFF6, 32'd3,        32'h55555552, 1'b0);
    // Aborts, each followed by a normal op
    abort(1, 1'b0);
    op(28, 3'b000, 32'd6,        32'd7,        32'h0000002A, 1'b0);
    abort(2, 1'b1);
    op(29, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);

    wait_idle();
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_done: got %0d ops outstanding want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the operand and result width (even, >= 8).
REQ-002 SHALL have parameter MUL_STAGES, default 2, meaning the number of multiply cycles spent in state MUL (>= 1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start  input  1  request an operation; held high by EX for as long as the instruction sits there.
REQ-006 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports a and b  input  XLEN each  rs1 and rs2 operands.
REQ-008 SHALL have port flush  input  1  kill any operation in progress.
REQ-009 SHALL have port stall  output  1  freeze the pipeline.
REQ-010 SHALL have port busy  output  1  an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result is valid.
REQ-012 SHALL have port result  output  XLEN  operation result.

Function
REQ-013 SHALL implement four states: IDLE, MUL, DIV, DONE.
REQ-014 In IDLE with start=1 and flush=0, the unit SHALL latch a, b and funct3 and go to MUL if funct3[2]=0, otherwise DIV; later changes on a, b or funct3 SHALL be ignored.
REQ-015 In MUL, the unit SHALL stay exactly MUL_STAGES cycles and then go to DONE.
REQ-016 In DIV, the unit SHALL perform one radix-2 restoring step per cycle on magnitudes for exactly XLEN cycles, then go to DONE.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; start SHALL NOT be sampled in DONE, so the same held instruction is never re-accepted.
REQ-018 Latency, counted from the start cycle as cycle 0, SHALL be: done at cycle MUL_STAGES+1 for multiply, at cycle XLEN+1 for divide.
REQ-019 Outputs SHALL be: stall = start & (state != DONE) & ~flush; busy = (state is MUL or DIV); done = (state == DONE).
REQ-020 result SHALL be registered, SHALL change only when entering DONE, and SHALL hold until the next DONE.
REQ-021 Multiply SHALL form a 2*XLEN product: MUL returns the low half; MULH uses signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned, each returning the high half.
REQ-022 Divide SHALL take operand signs only for DIV and REM; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-023 For b=0: quotient SHALL be all ones and remainder SHALL be a.
REQ-024 For signed a = -2^(XLEN-1) with b = -1: quotient SHALL be a and remainder SHALL be 0.
REQ-025 flush=1 in any state SHALL force IDLE on the next edge with no done pulse; result SHALL keep its previous value.
REQ-026 If flush and start are both high in IDLE, flush SHALL win and nothing is accepted.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, result 0, and all internal counters and operand registers 0.
REQ-028 While reset=0, outputs SHALL be busy=0, done=0 and stall=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-030 The first start is accepted on the first rising edge after reset is released.

Configuration
REQ-031 Macro MULDIV_EARLY_OUT_EN SHALL control early termination of divides.
REQ-032 With MULDIV_EARLY_OUT_EN defined, a divide SHALL go from IDLE directly to DONE (done at cycle 1) when b=0, when the REQ-024 overflow case applies, or when |a| < |b|; results SHALL follow REQ-022..024 (for |a| < |b|: quotient 0, remainder a).
REQ-033 Without MULDIV_EARLY_OUT_EN, every divide SHALL take the full XLEN+1 latency, with identical results.

Verification
REQ-034 XLEN=32, MUL_STAGES=2, MUL a=7 b=-3 -> done at cycle 3, result 0xFFFFFFEB; stall high in cycles 0-2 and low in cycle 3.
REQ-035 MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU a=-1 b=2 -> result 0xFFFFFFFF.
REQ-036 DIV a=-7 b=2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each done at cycle 33 (macro off).
REQ-037 DIVU a=5 b=0 -> 0xFFFFFFFF; REM a=0x80000000 b=-1 -> 0; with the macro on, both have done at cycle 1.
REQ-038 Start DIV, assert flush at cycle 10 -> IDLE at cycle 11, no done, result unchanged; repeat with reset=0 at cycle 10 -> result 0.
REQ-039 start held high through DONE -> exactly one done pulse and the unit returns to IDLE.
